// File: rtl/riscv_mext_pkg.sv
// Types and sizing shared by the M-extension execute units.
package riscv_mext_pkg;
   localparam int DIV_XLEN = 64;
   localparam int CNT_W    = $clog2(DIV_XLEN) + 1;

   typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_t;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/sign_pkg.sv
// Shared operand-widening helpers: widen a register value by one sign or zero bit so that
// taking a magnitude can never overflow.
package sign_pkg;
   localparam int SIGN_XLEN = 64;
   localparam int SIGN_HW   = SIGN_XLEN / 2;

   function automatic logic [SIGN_XLEN:0] as_signed(input logic [SIGN_XLEN-1:0] x);
      return {x[SIGN_XLEN-1], x};
   endfunction

   function automatic logic [SIGN_XLEN:0] as_unsigned(input logic [SIGN_XLEN-1:0] x);
      return {1'b0, x};
   endfunction

   function automatic logic [SIGN_HW:0] as_signedw(input logic [SIGN_HW-1:0] x);
      return {x[SIGN_HW-1], x};
   endfunction

   function automatic logic [SIGN_HW:0] as_unsignedw(input logic [SIGN_HW-1:0] x);
      return {1'b0, x};
   endfunction
endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and shift the resulting quotient bit into the dividend register.
module riscv_div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W-1:0] dsr_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] dvd_o
);
   logic [W:0]   trial;
   logic [W-1:0] diff;
   logic         ge;

   assign trial = {rem_i, dvd_i[W-1]};
   assign ge    = trial >= {1'b0, dsr_i};
   // The partial remainder stays below the divisor, so a W-bit difference is exact when ge is set.
   assign diff  = trial[W-1:0] - dsr_i;
   assign rem_o = ge ? diff : trial[W-1:0];
   assign dvd_o = {dvd_i[W-2:0], ge};
endmodule

// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W variants.
// Magnitudes are divided MSB-first, then the sign is fixed up in a single extra cycle.
module riscv_div_unit
   import riscv_mext_pkg::*;
   import sign_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            i_riscv_div_clk,
   input  logic            i_riscv_div_rstn,
   input  logic            i_riscv_div_start,
   input  logic            i_riscv_div_kill,
   input  logic [1:0]      i_riscv_div_op,
   input  logic            i_riscv_div_word,
   input  logic [XLEN-1:0] i_riscv_div_rs1,
   input  logic [XLEN-1:0] i_riscv_div_rs2,
   output logic [XLEN-1:0] o_riscv_div_result,
   output logic            o_riscv_div_valid,
   output logic            o_riscv_div_busy
);
   localparam int HW = XLEN / 2;
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

   div_state_t       state_q;
   logic [XLEN-1:0]  result_q;
   logic             valid_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  dvd_q;
   logic [XLEN-1:0]  dsr_q;
   logic             neg_res_q;
   logic             is_rem_q;
   logic             word_q;

   div_op_t          op_d;
   logic             signed_d;
   logic             is_rem_d;
   logic [HW:0]      aw_d;
   logic [HW:0]      bw_d;
   logic [XLEN:0]    a_wide_d;
   logic [XLEN:0]    b_wide_d;
   logic             neg_a_d;
   logic             neg_b_d;
   logic [XLEN-1:0]  mag_a_d;
   logic [XLEN-1:0]  mag_b_d;
   logic             b_zero_d;
   logic             ovf_d;
   logic             special_d;
   logic [XLEN-1:0]  dvd_sext_d;
   logic [XLEN-1:0]  spec_res_d;
   logic [XLEN-1:0]  step_rem_d;
   logic [XLEN-1:0]  step_dvd_d;
   logic [CNT_W-1:0] cnt_last_d;
   logic [XLEN-1:0]  raw_d;
   logic [XLEN-1:0]  signed_raw_d;
   logic [XLEN-1:0]  fix_res_d;

   assign op_d     = div_op_t'(i_riscv_div_op);
   assign signed_d = (op_d == DIV) || (op_d == REM);
   assign is_rem_d = (op_d == REM) || (op_d == REMU);

   always_comb begin
      aw_d = signed_d ? as_signedw(i_riscv_div_rs1[HW-1:0]) : as_unsignedw(i_riscv_div_rs1[HW-1:0]);
      bw_d = signed_d ? as_signedw(i_riscv_div_rs2[HW-1:0]) : as_unsignedw(i_riscv_div_rs2[HW-1:0]);
      if (i_riscv_div_word) begin
         a_wide_d = {{HW{aw_d[HW]}}, aw_d};
         b_wide_d = {{HW{bw_d[HW]}}, bw_d};
      end else begin
         a_wide_d = signed_d ? as_signed(i_riscv_div_rs1) : as_unsigned(i_riscv_div_rs1);
         b_wide_d = signed_d ? as_signed(i_riscv_div_rs2) : as_unsigned(i_riscv_div_rs2);
      end
   end

   assign neg_a_d = a_wide_d[XLEN];
   assign neg_b_d = b_wide_d[XLEN];
   assign mag_a_d = neg_a_d ? -a_wide_d[XLEN-1:0] : a_wide_d[XLEN-1:0];
   assign mag_b_d = neg_b_d ? -b_wide_d[XLEN-1:0] : b_wide_d[XLEN-1:0];

   assign b_zero_d = i_riscv_div_word ? (i_riscv_div_rs2[HW-1:0] == '0) : (i_riscv_div_rs2 == '0);
   assign ovf_d    = signed_d && (i_riscv_div_word
                     ? (i_riscv_div_rs1[HW-1:0] == MIN_D[XLEN-1:HW] && i_riscv_div_rs2[HW-1:0] == '1)
                     : (i_riscv_div_rs1 == MIN_D && i_riscv_div_rs2 == '1));
   assign special_d  = b_zero_d || ovf_d;
   assign dvd_sext_d = i_riscv_div_word ? {{HW{i_riscv_div_rs1[HW-1]}}, i_riscv_div_rs1[HW-1:0]}
                                        : i_riscv_div_rs1;

   always_comb begin
      spec_res_d = '0;
      if (b_zero_d)
         spec_res_d = is_rem_d ? dvd_sext_d : '1;
      else if (!is_rem_d)
         spec_res_d = i_riscv_div_word ? MIN_W : MIN_D;
   end

   riscv_div_step #(.W(XLEN)) u_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dsr_i (dsr_q),
      .rem_o (step_rem_d),
      .dvd_o (step_dvd_d)
   );

   // After the last step the quotient sits in dvd_q (low half for word ops) and the remainder in rem_q.
   assign cnt_last_d   = word_q ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
   assign raw_d        = is_rem_q ? rem_q : dvd_q;
   assign signed_raw_d = neg_res_q ? -raw_d : raw_d;
   assign fix_res_d    = word_q ? {{HW{signed_raw_d[HW-1]}}, signed_raw_d[HW-1:0]} : signed_raw_d;

   always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rstn) begin
      if (!i_riscv_div_rstn) begin
         state_q   <= IDLE;
         result_q  <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         neg_res_q <= 1'b0;
         is_rem_q  <= 1'b0;
         word_q    <= 1'b0;
      end else if (i_riscv_div_kill) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (i_riscv_div_start) begin
                  busy_q <= 1'b1;
                  if (special_d) begin
                     result_q <= spec_res_d;
                     valid_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     cnt_q     <= '0;
                     rem_q     <= '0;
                     dvd_q     <= i_riscv_div_word ? {mag_a_d[HW-1:0], {HW{1'b0}}} : mag_a_d;
                     dsr_q     <= mag_b_d;
                     neg_res_q <= is_rem_d ? neg_a_d : (neg_a_d ^ neg_b_d);
                     is_rem_q  <= is_rem_d;
                     word_q    <= i_riscv_div_word;
                     state_q   <= CALC;
                  end
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CALC: begin
               rem_q <= step_rem_d;
               dvd_q <= step_dvd_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == cnt_last_d)
                  state_q <= FIX;
            end
            FIX: begin
               result_q <= fix_res_d;
               valid_q  <= 1'b1;
               state_q  <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_riscv_div_result = result_q;
   assign o_riscv_div_valid  = valid_q;
   assign o_riscv_div_busy   = busy_q;
endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed testbench for riscv_div_unit: arithmetic, special cases, word ops, kill and reset.
module tb_riscv_div_unit;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [1:0]  op = 2'd0;
   logic        word = 1'b0;
   logic [63:0] rs1 = '0;
   logic [63:0] rs2 = '0;
   logic [63:0] result;
   logic        valid;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   logic [63:0] r_res;
   int          r_lat;
   bit          r_busy_ok;

   localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

   riscv_div_unit dut (
      .i_riscv_div_clk    (clk),
      .i_riscv_div_rstn   (rstn),
      .i_riscv_div_start  (start),
      .i_riscv_div_kill   (kill),
      .i_riscv_div_op     (op),
      .i_riscv_div_word   (word),
      .i_riscv_div_rs1    (rs1),
      .i_riscv_div_rs2    (rs2),
      .o_riscv_div_result (result),
      .o_riscv_div_valid  (valid),
      .o_riscv_div_busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic drive_start(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
      op = o; word = w; rs1 = a; rs2 = b; start = 1'b1;
   endtask

   // Leaves the bench 1 time unit into cycle 1 (start accepted at the end of cycle 0).
   task automatic launch(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
      @(posedge clk); #1;
      drive_start(o, w, a, b);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called in cycle 1; returns the cycle of the valid pulse (999 on timeout).
   task automatic wait_done();
      r_lat = 999; r_busy_ok = 1'b1; r_res = 'x;
      for (int c = 1; c < 200; c++) begin
         if (busy !== 1'b1) r_busy_ok = 1'b0;
         if (valid === 1'b1) begin
            r_lat = c; r_res = result;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
      launch(o, w, a, b);
      wait_done();
      $display("op=%0d w=%0d rs1=%h rs2=%h result=%h lat=%0d", o, w, a, b, r_res, r_lat);
      total++;
      if (r_res !== exp) begin
         bad++; $display("FAIL result op=%0d w=%0d got %h want %h", o, w, r_res, exp);
      end
      total++;
      if (r_lat !== exp_lat) begin
         bad++; $display("FAIL latency op=%0d w=%0d got %0d want %0d", o, w, r_lat, exp_lat);
      end
      total++;
      if (r_busy_ok !== 1'b1) begin
         bad++; $display("FAIL busy_during_op op=%0d w=%0d got low want high", o, w);
      end
   endtask

   task automatic test_reset();
      #3;
      $display("reset: result=%h valid=%b busy=%b", result, valid, busy);
      total++;
      if (result !== 64'h0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_div_basic();
      run_vec(OP_DIV, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
      @(posedge clk); #1;
      $display("after_done: valid=%b busy=%b", valid, busy);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got %b want 0", valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_done got %b want 0", busy); end
      total++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         bad++; $display("FAIL result_hold got %h want FFFFFFFFFFFFFFFA", result);
      end
   endtask

   task automatic test_arith();
      run_vec(OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
      run_vec(OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run_vec(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
      run_vec(OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66);
      run_vec(OP_REM,  1'b0, 64'd20, -64'sd3, 64'd2, 66);
      run_vec(OP_DIV,  1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
   endtask

   task automatic test_special();
      run_vec(OP_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_vec(OP_REM,  1'b0, 64'd5, 64'd0, 64'd5, 1);
      run_vec(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      run_vec(OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      run_vec(OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      run_vec(OP_REMU, 1'b1, 64'hAAAA_AAAA_8000_0001, 64'h1234_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
   endtask

   task automatic test_word();
      run_vec(OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
      run_vec(OP_REM,  1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
      run_vec(OP_DIV,  1'b1, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 34);
      run_vec(OP_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 34);
      run_vec(OP_DIV,  1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34);
   endtask

   task automatic test_kill();
      bit saw_valid;
      run_vec(OP_DIV, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      launch(OP_DIVU, 1'b0, 64'd100, 64'd7);
      saw_valid = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (valid === 1'b1) saw_valid = 1'b1;
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      $display("kill: cycle11 valid=%b busy=%b result=%h", valid, busy, result);
      total++;
      if (saw_valid !== 1'b0) begin bad++; $display("FAIL kill_early_valid got 1 want 0"); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy got %b want 0", busy); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL kill_valid got %b want 0", valid); end
      total++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++; $display("FAIL kill_result_kept got %h want FFFFFFFFFFFFFFFF", result);
      end
      drive_start(OP_DIVU, 1'b0, 64'd1000, 64'd10);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      $display("restart after kill: result=%h lat=%0d", r_res, r_lat);
      total++;
      if (r_res !== 64'd100) begin bad++; $display("FAIL restart_result got %h want 64", r_res); end
      total++;
      if (r_lat !== 66) begin bad++; $display("FAIL restart_latency got %0d want 66", r_lat); end
      // Kill wins over a simultaneous start.
      @(posedge clk); #1;
      drive_start(OP_DIVU, 1'b0, 64'd9, 64'd3);
      kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      $display("kill+start: busy=%b valid=%b", busy, valid);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL kill_priority_busy got %b want 0", busy); end
   endtask

   task automatic test_start_ignored();
      launch(OP_DIVU, 1'b0, 64'd100, 64'd7);
      for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
      drive_start(OP_REMU, 1'b0, 64'd1000, 64'd10);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      $display("start during CALC: result=%h lat=%0d", r_res, r_lat);
      total++;
      if (r_res !== 64'd14) begin bad++; $display("FAIL ignored_start_result got %h want E", r_res); end
      total++;
      if (r_lat !== 61) begin bad++; $display("FAIL ignored_start_latency got %0d want 61", r_lat); end
   endtask

   task automatic test_reset_mid();
      launch(OP_DIV, 1'b0, -64'sd20, 64'd3);
      for (int c = 1; c < 20; c++) begin @(posedge clk); #1; end
      #1;
      rstn = 1'b0;
      #1;
      $display("reset mid-op: result=%h valid=%b busy=%b", result, valid, busy);
      total++;
      if (result !== 64'h0) begin bad++; $display("FAIL midreset_result got %h want 0", result); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", busy); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got %b want 0", valid); end
      @(posedge clk); @(negedge clk);
      rstn = 1'b1;
      run_vec(OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
   endtask

   initial begin
      test_reset();
      test_div_basic();
      test_arith();
      test_special();
      test_word();
      test_kill();
      test_start_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
